// File: rtl/proc_pkg.sv
// Shared constants and FSM state type for the 8-bit processor front end.
package proc_pkg;
  localparam int unsigned PC_W_DEF     = 10;
  localparam int unsigned INSTR_W      = 8;
  localparam int unsigned START_PC_DEF = 0;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} fetch_state_e;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: start control, decoder feedback, instruction memory and status.
interface fetch_unit_if import proc_pkg::*; #(
  parameter int unsigned PC_W = PC_W_DEF
);
  logic               start_i;
  logic               branchf_i;
  logic               branchb_i;
  logic               done_i;
  logic [PC_W-1:0]    branch_offset_i;
  logic [PC_W-1:0]    imem_addr_o;
  logic [INSTR_W-1:0] imem_data_i;
  logic [INSTR_W-1:0] instruction_o;
  logic               instr_valid_o;
  logic [PC_W-1:0]    pc_o;
  logic               halted_o;
  logic [15:0]        cycle_count_o;

  modport master (
    input  start_i, branchf_i, branchb_i, done_i, branch_offset_i, imem_data_i,
    output imem_addr_o, instruction_o, instr_valid_o, pc_o, halted_o, cycle_count_o
  );

  modport slave (
    output start_i, branchf_i, branchb_i, done_i, branch_offset_i, imem_data_i,
    input  imem_addr_o, instruction_o, instr_valid_o, pc_o, halted_o, cycle_count_o
  );
endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC priority mux: done holds, forward branch beats backward, else increment (mod 2^PC_W).
module next_pc_sel #(
  parameter int unsigned PC_W = 10
) (
  input  logic [PC_W-1:0] pc,
  input  logic            done,
  input  logic            branchf,
  input  logic            branchb,
  input  logic [PC_W-1:0] offset,
  output logic [PC_W-1:0] next_pc
);
  always_comb begin
    next_pc = pc + PC_W'(1);
    if (done)         next_pc = pc;
    else if (branchf) next_pc = pc + offset;
    else if (branchb) next_pc = pc - offset;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, run/halt FSM, zero-bubble synchronous imem fetch.
// Optional executed-instruction counter enabled by `define CYCLE_COUNT_EN.
module fetch_unit import proc_pkg::*; #(
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter int unsigned START_PC = START_PC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);
  localparam logic [PC_W-1:0] START_ADDR = PC_W'(START_PC);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, next_pc;
  logic               halted_q, halted_d;
  logic               valid;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] instr;

  next_pc_sel #(.PC_W(PC_W)) u_next_pc_sel (
    .pc      (pc_q),
    .done    (bus.done_i),
    .branchf (bus.branchf_i),
    .branchb (bus.branchb_i),
    .offset  (bus.branch_offset_i),
    .next_pc (next_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= START_ADDR;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    halted_d  = halted_q;
    imem_addr = pc_q;
    valid     = 1'b0;
    instr     = '0;
    unique case (state_q)
      IDLE: begin
        imem_addr = START_ADDR;
        if (bus.start_i) begin
          state_d = LOAD;
          pc_d    = START_ADDR;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        // Address the next PC now so its data lands as pc_q updates.
        valid     = 1'b1;
        instr     = bus.imem_data_i;
        imem_addr = next_pc;
        pc_d      = next_pc;
        if (bus.done_i) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end
      end
      HALT: begin
        if (bus.start_i) begin
          state_d  = LOAD;
          pc_d     = START_ADDR;
          halted_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_addr_o   = imem_addr;
  assign bus.instruction_o = instr;
  assign bus.instr_valid_o = valid;
  assign bus.pc_o          = pc_q;
  assign bus.halted_o      = halted_q;

`ifdef CYCLE_COUNT_EN
  logic        start_accept;
  logic [15:0] count_q;

  assign start_accept = bus.start_i && ((state_q == IDLE) || (state_q == HALT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         count_q <= '0;
    else if (start_accept)             count_q <= '0;
    else if (valid && (count_q != '1)) count_q <= count_q + 16'd1;
  end

  assign bus.cycle_count_o = count_q;
`else
  assign bus.cycle_count_o = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: bench-side PC model pushes expected (pc, instr) pairs.
module tb_fetch_unit;
  import proc_pkg::*;

  localparam int unsigned PC_W = 10;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [7:0]      instr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  fetch_unit_if #(.PC_W(PC_W)) bus ();

  fetch_unit #(.PC_W(PC_W), .START_PC(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1024];
  always @(posedge clk) bus.imem_data_i <= mem[bus.imem_addr_o];

  exp_t            sb[$];
  int              total = 0;
  int              bad   = 0;
  logic [PC_W-1:0] model_pc;
  int unsigned     n_exec;

  function automatic logic [15:0] exp_count(input int unsigned n);
`ifdef CYCLE_COUNT_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset === 1'b0 && bus.instr_valid_o === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: got pc=%0d instr=%h, none required", bus.pc_o, bus.instruction_o);
      end else begin
        e = sb.pop_front();
        if (bus.pc_o !== e.pc || bus.instruction_o !== e.instr) begin
          bad++;
          $display("FAIL fetch: got pc=%0d instr=%h, required pc=%0d instr=%h",
                   bus.pc_o, bus.instruction_o, e.pc, e.instr);
        end
      end
    end
  end

  task automatic drive(input logic f, input logic b, input logic d, input logic [PC_W-1:0] off);
    logic [PC_W-1:0] nxt;
    bus.branchf_i       = f;
    bus.branchb_i       = b;
    bus.done_i          = d;
    bus.branch_offset_i = off;
    if (d)      nxt = model_pc;
    else if (f) nxt = model_pc + off;
    else if (b) nxt = model_pc - off;
    else        nxt = model_pc + 10'd1;
    n_exec++;
    if (!d) sb.push_back({nxt, mem[nxt]});
    model_pc = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.start_i         = 1'b0;
    bus.branchf_i       = 1'b0;
    bus.branchb_i       = 1'b0;
    bus.done_i          = 1'b0;
    bus.branch_offset_i = '0;
  endtask

  task automatic start_pulse();
    bus.start_i = 1'b1;
    model_pc    = '0;
    n_exec      = 0;
    sb.push_back({10'd0, mem[0]});
    tick();
  endtask

  task automatic test_reset();
    total++;
    if (bus.pc_o !== 10'd0 || bus.instr_valid_o !== 1'b0 || bus.halted_o !== 1'b0 ||
        bus.instruction_o !== 8'd0 || bus.imem_addr_o !== 10'd0 || bus.cycle_count_o !== 16'd0) begin
      bad++;
      $display("FAIL reset_vals: got pc=%0d v=%b h=%b ins=%h addr=%0d cnt=%0d, required all zero",
               bus.pc_o, bus.instr_valid_o, bus.halted_o, bus.instruction_o, bus.imem_addr_o, bus.cycle_count_o);
    end
  endtask

  task automatic test_sequential();
    start_pulse();
    total++;
    if (bus.instr_valid_o !== 1'b0 || bus.halted_o !== 1'b0 || bus.imem_addr_o !== 10'd0) begin
      bad++;
      $display("FAIL load_bubble: got v=%b h=%b addr=%0d, required 0 0 0",
               bus.instr_valid_o, bus.halted_o, bus.imem_addr_o);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, '0);
      tick();
    end
    total++;
    if (bus.pc_o !== 10'd5 || bus.instr_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL seq_pc: got pc=%0d v=%b, required pc=5 v=1", bus.pc_o, bus.instr_valid_o);
    end
  endtask

  task automatic test_branch_fwd();
    drive(1'b1, 1'b0, 1'b0, 10'd4);
    #1;
    total++;
    if (bus.imem_addr_o !== 10'd9) begin
      bad++;
      $display("FAIL fwd_addr: got %0d, required 9", bus.imem_addr_o);
    end
    tick();
    total++;
    if (bus.pc_o !== 10'd9 || bus.instr_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL fwd_pc: got pc=%0d v=%b, required pc=9 v=1", bus.pc_o, bus.instr_valid_o);
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 1'b0, 10'd6);
    tick();
    drive(1'b0, 1'b1, 1'b0, 10'd5);
    #1;
    total++;
    if (bus.imem_addr_o !== 10'd1022) begin
      bad++;
      $display("FAIL bwd_wrap_addr: got %0d, required 1022", bus.imem_addr_o);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    total++;
    if (bus.pc_o !== 10'd1023) begin
      bad++;
      $display("FAIL pc_max: got %0d, required 1023", bus.pc_o);
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    #1;
    total++;
    if (bus.imem_addr_o !== 10'd0) begin
      bad++;
      $display("FAIL inc_wrap_addr: got %0d, required 0", bus.imem_addr_o);
    end
    tick();
  endtask

  task automatic test_both_branches();
    drive(1'b1, 1'b0, 1'b0, 10'd10);
    tick();
    drive(1'b1, 1'b1, 1'b0, 10'd2);
    #1;
    total++;
    if (bus.imem_addr_o !== 10'd12) begin
      bad++;
      $display("FAIL both_addr: got %0d, required 12", bus.imem_addr_o);
    end
    tick();
    drive(1'b0, 1'b0, 1'b1, '0);
    tick();
    total++;
    if (bus.halted_o !== 1'b1 || bus.pc_o !== 10'd12 || bus.cycle_count_o !== exp_count(n_exec)) begin
      bad++;
      $display("FAIL first_halt: got h=%b pc=%0d cnt=%0d, required h=1 pc=12 cnt=%0d",
               bus.halted_o, bus.pc_o, bus.cycle_count_o, exp_count(n_exec));
    end
  endtask

  task automatic test_halt();
    start_pulse();
    total++;
    if (bus.instr_valid_o !== 1'b0 || bus.halted_o !== 1'b0 || bus.cycle_count_o !== 16'd0) begin
      bad++;
      $display("FAIL restart_load: got v=%b h=%b cnt=%0d, required 0 0 0",
               bus.instr_valid_o, bus.halted_o, bus.cycle_count_o);
    end
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, 1'b0, '0);
      if (i == 3) bus.start_i = 1'b1;
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, '0);
    #1;
    total++;
    if (bus.imem_addr_o !== 10'd7) begin
      bad++;
      $display("FAIL done_addr: got %0d, required 7", bus.imem_addr_o);
    end
    tick();
    for (int c = 0; c < 20; c++) begin
      total++;
      if (bus.halted_o !== 1'b1 || bus.instr_valid_o !== 1'b0 || bus.pc_o !== 10'd7 ||
          bus.instruction_o !== 8'd0 || bus.cycle_count_o !== exp_count(8)) begin
        bad++;
        $display("FAIL halt_hold[%0d]: got h=%b v=%b pc=%0d ins=%h cnt=%0d, required h=1 v=0 pc=7 ins=00 cnt=%0d",
                 c, bus.halted_o, bus.instr_valid_o, bus.pc_o, bus.instruction_o, bus.cycle_count_o, exp_count(8));
      end
      tick();
    end
    start_pulse();
    total++;
    if (bus.instr_valid_o !== 1'b0 || bus.halted_o !== 1'b0 || bus.pc_o !== 10'd0 ||
        bus.cycle_count_o !== 16'd0) begin
      bad++;
      $display("FAIL restart2: got v=%b h=%b pc=%0d cnt=%0d, required 0 0 0 0",
               bus.instr_valid_o, bus.halted_o, bus.pc_o, bus.cycle_count_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b0, 1'b0, '0);
      tick();
    end
    total++;
    if (bus.pc_o !== 10'd40 || bus.cycle_count_o !== exp_count(40)) begin
      bad++;
      $display("FAIL pc40: got pc=%0d cnt=%0d, required pc=40 cnt=%0d",
               bus.pc_o, bus.cycle_count_o, exp_count(40));
    end
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (bus.instr_valid_o !== 1'b0 || bus.pc_o !== 10'd0 || bus.halted_o !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_reset[%0d]: got v=%b pc=%0d h=%b, required 0 0 0",
                 c, bus.instr_valid_o, bus.pc_o, bus.halted_o);
      end
    end
    start_pulse();
    tick();
    total++;
    if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== 10'd0) begin
      bad++;
      $display("FAIL resume: got v=%b pc=%0d, required v=1 pc=0", bus.instr_valid_o, bus.pc_o);
    end
    drive(1'b0, 1'b0, 1'b1, '0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3) ^ 8'(i >> 8);
    reset               = 1'b1;
    bus.start_i         = 1'b0;
    bus.branchf_i       = 1'b0;
    bus.branchb_i       = 1'b0;
    bus.done_i          = 1'b0;
    bus.branch_offset_i = '0;
    model_pc            = '0;
    n_exec              = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    tick();
    test_sequential();
    test_branch_fwd();
    test_wrap();
    test_both_branches();
    test_halt();
    test_reset_mid_run();
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
